// File: rtl/phaser_cal_pkg.sv
// Shared definitions for the PHASER_IN fine-delay read calibration sequencer:
// FSM states, error codes and fixed timing constants.
package phaser_cal_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_LOCK,
        DQS_RST,
        WAIT_DQS,
        SAMPLE,
        STEP,
        SETTLE,
        EVAL,
        CENTER,
        DONE,
        ERROR
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_LOCK_TMO   = 3'd1;
    localparam logic [2:0] ERR_DQS_TMO    = 3'd2;
    localparam logic [2:0] ERR_DQS_OOR    = 3'd3;
    localparam logic [2:0] ERR_SAMPLE_TMO = 3'd4;
    localparam logic [2:0] ERR_WINDOW     = 3'd5;
    localparam logic [2:0] ERR_FINE_OVF   = 3'd6;

    localparam int DQS_RST_CYCLES = 4;

    // Wide enough for the largest wait (lock timeout) minus one.
    localparam int TMR_W = 13;

endpackage

// File: rtl/phaser_cal_timer.sv
// Loadable down-counter shared by every timed wait of the calibration FSM.
// Loading N gives an expire flag on the (N+1)th cycle after the load.
module phaser_cal_timer #(
    parameter int W = 13
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/phaser_in_fine_cal.sv
// Read-path fine-delay calibration: sweeps PHASER_IN fine taps, finds the passing
// window and parks at its centre. Define PHASER_IN_FINE_CAL_RECAL_EN to restart on lock loss in DONE.
module phaser_in_fine_cal
    import phaser_cal_pkg::*;
#(
    parameter int TAP_W          = 6,
    parameter int MAX_TAP        = 63,
    parameter int SETTLE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int DQS_TIMEOUT    = 1024,
    parameter int SAMPLE_TIMEOUT = 256,
    parameter int MIN_WINDOW     = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             phaselocked,
    input  logic             dqsfound,
    input  logic             dqsoutofrange,
    input  logic             fineoverflow,
    output logic             sample_req,
    input  logic             sample_valid,
    input  logic             sample_match,
    output logic             rstdqsfind,
    output logic             fineenable,
    output logic             fineinc,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_err,
    output logic [2:0]       err_code,
    output logic [TAP_W-1:0] left_edge,
    output logic [TAP_W-1:0] right_edge,
    output logic [TAP_W-1:0] cur_tap
);

    state_t           state_q, state_d;
    logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic [TAP_W-1:0] left_q, left_d;
    logic [TAP_W-1:0] right_q, right_d;
    logic [TAP_W-1:0] target_q, target_d;
    logic             left_found_q, left_found_d;
    logic             centering_q, centering_d;
    logic [2:0]       err_q, err_d;
    logic             sample_req_q;

    logic             busy;
    logic             restart;
    logic [TAP_W:0]   width;
    logic [TAP_W:0]   sum;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    phaser_cal_timer #(.W(TMR_W)) u_timer (
        .clk_i      (sys_clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    assign busy  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign width = {1'b0, right_q} - {1'b0, left_q} + (TAP_W+1)'(1);
    assign sum   = {1'b0, left_q} + {1'b0, right_q};

    always_comb begin
        state_d      = state_q;
        cur_tap_d    = cur_tap_q;
        left_d       = left_q;
        right_d      = right_q;
        target_d     = target_q;
        left_found_d = left_found_q;
        centering_d  = centering_q;
        err_d        = err_q;
        fineenable   = 1'b0;
        fineinc      = 1'b0;
        restart      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) restart = 1'b1;
            end
            WAIT_LOCK: begin
                if (phaselocked) begin
                    state_d = DQS_RST;
                end else if (tmr_expired) begin
                    state_d = ERROR;
                    err_d   = ERR_LOCK_TMO;
                end
            end
            DQS_RST: begin
                if (tmr_expired) state_d = WAIT_DQS;
            end
            WAIT_DQS: begin
                if (dqsoutofrange) begin
                    state_d = ERROR;
                    err_d   = ERR_DQS_OOR;
                end else if (dqsfound) begin
                    state_d   = SAMPLE;
                    cur_tap_d = '0;
                end else if (tmr_expired) begin
                    state_d = ERROR;
                    err_d   = ERR_DQS_TMO;
                end
            end
            SAMPLE: begin
                if (sample_valid) begin
                    if (sample_match) begin
                        // First pass also seeds the right edge so a one-tap window has width 1.
                        if (!left_found_q) begin
                            left_d       = cur_tap_q;
                            left_found_d = 1'b1;
                        end
                        right_d = cur_tap_q;
                        state_d = (cur_tap_q == TAP_W'(MAX_TAP)) ? EVAL : STEP;
                    end else begin
                        state_d = left_found_q ? EVAL : STEP;
                    end
                end else if (tmr_expired) begin
                    state_d = ERROR;
                    err_d   = ERR_SAMPLE_TMO;
                end
            end
            STEP: begin
                // Only a failing top tap with no window yet reaches STEP at MAX_TAP.
                if (cur_tap_q == TAP_W'(MAX_TAP)) begin
                    state_d = ERROR;
                    err_d   = ERR_WINDOW;
                end else begin
                    fineenable = 1'b1;
                    fineinc    = 1'b1;
                    cur_tap_d  = cur_tap_q + TAP_W'(1);
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_expired) state_d = centering_q ? CENTER : SAMPLE;
            end
            EVAL: begin
                if (width < (TAP_W+1)'(MIN_WINDOW)) begin
                    state_d = ERROR;
                    err_d   = ERR_WINDOW;
                end else begin
                    target_d    = sum[TAP_W:1];
                    centering_d = 1'b1;
                    state_d     = CENTER;
                end
            end
            CENTER: begin
                if (cur_tap_q != target_q) begin
                    fineenable = 1'b1;
                    cur_tap_d  = cur_tap_q - TAP_W'(1);
                    state_d    = SETTLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    restart = 1'b1;
                end
`ifdef PHASER_IN_FINE_CAL_RECAL_EN
                else if (!phaselocked) begin
                    restart = 1'b1;
                end
`endif
            end
            ERROR: begin
                if (start) restart = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            state_d      = WAIT_LOCK;
            left_d       = '0;
            right_d      = '0;
            target_d     = '0;
            left_found_d = 1'b0;
            centering_d  = 1'b0;
            err_d        = ERR_NONE;
        end

        // Overflow overrides everything, including a tap move decided above.
        if (busy && fineoverflow) begin
            state_d    = ERROR;
            err_d      = ERR_FINE_OVF;
            cur_tap_d  = cur_tap_q;
            fineenable = 1'b0;
            fineinc    = 1'b0;
        end

        tmr_load = (state_d != state_q);
        case (state_d)
            WAIT_LOCK: tmr_val = TMR_W'(LOCK_TIMEOUT - 1);
            DQS_RST:   tmr_val = TMR_W'(DQS_RST_CYCLES - 1);
            WAIT_DQS:  tmr_val = TMR_W'(DQS_TIMEOUT - 1);
            SAMPLE:    tmr_val = TMR_W'(SAMPLE_TIMEOUT - 1);
            SETTLE:    tmr_val = TMR_W'(SETTLE_CYCLES - 1);
            default:   tmr_val = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_tap_q    <= '0;
            left_q       <= '0;
            right_q      <= '0;
            target_q     <= '0;
            left_found_q <= 1'b0;
            centering_q  <= 1'b0;
            err_q        <= ERR_NONE;
            sample_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_tap_q    <= cur_tap_d;
            left_q       <= left_d;
            right_q      <= right_d;
            target_q     <= target_d;
            left_found_q <= left_found_d;
            centering_q  <= centering_d;
            err_q        <= err_d;
            sample_req_q <= (state_d == SAMPLE) && (state_q != SAMPLE);
        end
    end

    assign sample_req = sample_req_q;
    assign rstdqsfind = (state_q == DQS_RST);
    assign cal_busy   = busy;
`ifdef PHASER_IN_FINE_CAL_RECAL_EN
    assign cal_done   = (state_q == DONE) && phaselocked;
`else
    assign cal_done   = (state_q == DONE);
`endif
    assign cal_err    = (state_q == ERROR);
    assign err_code   = err_q;
    assign left_edge  = left_q;
    assign right_edge = right_q;
    assign cur_tap    = cur_tap_q;

endmodule
